riscv_axi_master_arbiter: RTL
=============================

# riscv_axi_master_arbiter

Shares the RISC-V CPU's single AXI4-Lite master port (M00_AXI) between the instruction-fetch unit and the data load/store unit. It accepts one request at a time from either requester and runs the matching AXI4-Lite read or write on M00_AXI. It returns data and response status to the winning requester and keeps a sticky error flag for the system. It sits between the core pipeline and the M00_AXI interface of the CPU IP.

## Interface
- ADDR_W, 32, address width of requesters and AXI.
- DATA_W, 32, data width; DATA_W/8 strobe bits.
- ACLK  in  1  clock; all logic rising-edge.
- ARESET  in  1  asynchronous, active-high reset.
- if_req / if_addr  in  1 / ADDR_W  fetch request (read only) and its address.
- if_ack / if_rdata / if_err  out  1 / DATA_W / 1  fetch completion pulse, data, response-error.
- dm_req / dm_we / dm_addr  in  1 / 1 / ADDR_W  data request, 1 = write, address.
- dm_wdata / dm_wstrb  in  DATA_W / DATA_W/8  write data and byte strobes.
- dm_ack / dm_rdata / dm_err  out  1 / DATA_W / 1  data completion pulse, read data, response-error.
- M00_AXI_AWADDR / AWPROT / AWVALID  out  ADDR_W / 3 / 1; M00_AXI_AWREADY in 1.
- M00_AXI_WDATA / WSTRB / WVALID  out  DATA_W / DATA_W/8 / 1; M00_AXI_WREADY in 1.
- M00_AXI_BRESP / BVALID  in  2 / 1; M00_AXI_BREADY out 1.
- M00_AXI_ARADDR / ARPROT / ARVALID  out  ADDR_W / 3 / 1; M00_AXI_ARREADY in 1.
- M00_AXI_RDATA / RRESP / RVALID  in  DATA_W / 2 / 1; M00_AXI_RREADY out 1.
- busy  out  1  high in every state except IDLE.
- M00_AXI_ERROR  out  1  sticky; set by any non-OKAY BRESP/RRESP.

## Operation
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, DONE.
- IDLE: sample requests. Latch the winner's id, addr, wdata, wstrb and we. Go to WR_REQ if it is a data write, else RD_REQ. With no request, stay in IDLE.
- Requester rule: hold req and fields stable until ack. Drop req in the cycle after ack. A req still high in the cycle after ack is a new request.
- WR_REQ: AWVALID and WVALID rise together and each falls on its own handshake. Either handshake may complete first or both in the same cycle. Go to WR_RESP once both have completed.
- WR_RESP: BREADY=1. On the BVALID handshake, capture err = BRESP[1]; go to DONE.
- RD_REQ: ARVALID=1 until ARREADY; then RD_DATA.
- RD_DATA: RREADY=1. On RVALID, capture RDATA and err = RRESP[1]; go to DONE.
- DONE: one-cycle ack to the latched requester with rdata/err valid in that cycle; then IDLE.
- rdata holds its last captured value between acks. A write ack drives rdata = 0.
- ARPROT = 3'b100 for fetch, 3'b000 for data; AWPROT = 3'b000.
- M00_AXI_ERROR is cleared only by ARESET.
- Arbitration when both request in IDLE: see Configuration. A loser keeps req high and is served next.

## Timing
- Reset values: all VALID/READY outputs 0, if_ack/dm_ack 0, err outputs 0, rdata 0, busy 0, M00_AXI_ERROR 0, state IDLE, RR pointer = fetch.
- Request seen in IDLE at cycle 0: VALIDs high at cycle 1.
- Zero-wait slave, read: AR handshake cycle 1, R handshake cycle 2, ack cycle 3.
- Zero-wait slave, write: AW/W cycle 1, B cycle 2, ack cycle 3.
- Back-to-back: IDLE after DONE accepts a new request; issue-to-issue minimum is 4 cycles.
- ARESET mid-transaction: immediate return to IDLE and all outputs at reset values. The open AXI transaction is abandoned; the slave is reset by the same system reset.

## Configuration
- RISCV_AXI_ARB_RR_EN defined: round-robin. A one-bit pointer names the preferred requester and flips to the other requester after each grant.
- RISCV_AXI_ARB_RR_EN undefined: fixed priority, data wins over fetch, no pointer flop.

## Structure
- Package riscv_axi_arb_pkg: FSM state enum, requester id enum (REQ_IF, REQ_DM), AXI resp constants (OKAY, EXOKAY, SLVERR, DECERR), PROT constants.
- Sub-module riscv_axi_arb_select: combinational winner pick plus the RR pointer register. The pointer register is present only under RISCV_AXI_ARB_RR_EN.

## Test plan
- Fetch read at 0x0000_0100, slave returns 0xDEAD_BEEF OKAY -> if_ack at cycle 3, if_rdata 0xDEAD_BEEF, ARPROT 3'b100, if_err 0.
- Data write 0x1234_5678 to 0x40, strb 4'b0011; AWREADY delayed 3 cycles, WREADY immediate -> WVALID drops first, B accepted only after AW handshake, dm_ack 1 cycle.
- if_req and dm_req high together for 4 transactions -> fixed: 2×DM then 2×IF; with RR_EN: IF, DM, IF, DM.
- Read with RRESP=2'b10 -> dm_err 1 on ack, M00_AXI_ERROR stays 1 through following OKAY transactions until ARESET.
- ARESET pulsed while in WR_RESP -> outputs at reset values immediately, no ack. A later read completes normally.

Source files
------------

// File: rtl/riscv_axi_master_arbiter_pkg.sv
// Shared types and constants for the fetch/data AXI4-Lite master arbiter.
package riscv_axi_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_DATA = 3'd4,
    DONE    = 3'd5
  } arb_state_e;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_DM = 1'b1
  } req_id_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  localparam logic [2:0] PROT_INSTR = 3'b100;
  localparam logic [2:0] PROT_DATA  = 3'b000;

  // SLVERR and DECERR both carry bit 1; OKAY/EXOKAY do not.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/riscv_axi_master_arbiter_if.sv
// Requester ports plus the M00_AXI AXI4-Lite master bus, seen from the arbiter (master) or its environment (slave).
interface riscv_axi_master_arbiter_if;
  import riscv_axi_arb_pkg::*;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;
  logic              if_err;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [STRB_W-1:0] dm_wstrb;
  logic              dm_ack;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_err;

  logic [ADDR_W-1:0] M00_AXI_AWADDR;
  logic [2:0]        M00_AXI_AWPROT;
  logic              M00_AXI_AWVALID;
  logic              M00_AXI_AWREADY;
  logic [DATA_W-1:0] M00_AXI_WDATA;
  logic [STRB_W-1:0] M00_AXI_WSTRB;
  logic              M00_AXI_WVALID;
  logic              M00_AXI_WREADY;
  logic [1:0]        M00_AXI_BRESP;
  logic              M00_AXI_BVALID;
  logic              M00_AXI_BREADY;
  logic [ADDR_W-1:0] M00_AXI_ARADDR;
  logic [2:0]        M00_AXI_ARPROT;
  logic              M00_AXI_ARVALID;
  logic              M00_AXI_ARREADY;
  logic [DATA_W-1:0] M00_AXI_RDATA;
  logic [1:0]        M00_AXI_RRESP;
  logic              M00_AXI_RVALID;
  logic              M00_AXI_RREADY;

  logic              busy;
  logic              M00_AXI_ERROR;

  modport master (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb,
    output if_ack, if_rdata, if_err, dm_ack, dm_rdata, dm_err,
    output M00_AXI_AWADDR, M00_AXI_AWPROT, M00_AXI_AWVALID,
    input  M00_AXI_AWREADY,
    output M00_AXI_WDATA, M00_AXI_WSTRB, M00_AXI_WVALID,
    input  M00_AXI_WREADY,
    input  M00_AXI_BRESP, M00_AXI_BVALID,
    output M00_AXI_BREADY,
    output M00_AXI_ARADDR, M00_AXI_ARPROT, M00_AXI_ARVALID,
    input  M00_AXI_ARREADY,
    input  M00_AXI_RDATA, M00_AXI_RRESP, M00_AXI_RVALID,
    output M00_AXI_RREADY,
    output busy, M00_AXI_ERROR
  );

  modport slave (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb,
    input  if_ack, if_rdata, if_err, dm_ack, dm_rdata, dm_err,
    input  M00_AXI_AWADDR, M00_AXI_AWPROT, M00_AXI_AWVALID,
    output M00_AXI_AWREADY,
    input  M00_AXI_WDATA, M00_AXI_WSTRB, M00_AXI_WVALID,
    output M00_AXI_WREADY,
    output M00_AXI_BRESP, M00_AXI_BVALID,
    input  M00_AXI_BREADY,
    input  M00_AXI_ARADDR, M00_AXI_ARPROT, M00_AXI_ARVALID,
    output M00_AXI_ARREADY,
    output M00_AXI_RDATA, M00_AXI_RRESP, M00_AXI_RVALID,
    input  M00_AXI_RREADY,
    input  busy, M00_AXI_ERROR
  );

endinterface

// File: rtl/riscv_axi_master_arbiter_select.sv
// Winner pick between fetch and data requests; RISCV_AXI_ARB_RR_EN selects round-robin
// (with a one-bit preference pointer), otherwise data has fixed priority over fetch.
module riscv_axi_arb_select
  import riscv_axi_arb_pkg::*;
(
`ifdef RISCV_AXI_ARB_RR_EN
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    grant_en_i,
`endif
  input  logic    if_req_i,
  input  logic    dm_req_i,
  output logic    grant_valid_o,
  output req_id_e grant_id_o
);

  assign grant_valid_o = if_req_i | dm_req_i;

`ifdef RISCV_AXI_ARB_RR_EN
  req_id_e ptr_q;

  always_comb begin
    if (if_req_i && dm_req_i) begin
      grant_id_o = ptr_q;
    end else if (dm_req_i) begin
      grant_id_o = REQ_DM;
    end else begin
      grant_id_o = REQ_IF;
    end
  end

  // Pointer moves to the requester that did not just win.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= REQ_IF;
    end else if (grant_en_i && grant_valid_o) begin
      ptr_q <= (grant_id_o == REQ_IF) ? REQ_DM : REQ_IF;
    end
  end
`else
  assign grant_id_o = dm_req_i ? REQ_DM : REQ_IF;
`endif

endmodule

// File: rtl/riscv_axi_master_arbiter.sv
// Shares one AXI4-Lite master between instruction fetch and data load/store.
// Arbitration policy set by RISCV_AXI_ARB_RR_EN (round-robin) or fixed data-first when undefined.
module riscv_axi_master_arbiter
  import riscv_axi_arb_pkg::*;
(
  input  logic                       ACLK,
  input  logic                       ARESET,
  riscv_axi_master_arbiter_if.master bus
);

  arb_state_e        state_q, state_d;
  req_id_e           id_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic              aw_done_q, w_done_q;
  logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;
  logic              if_err_q, dm_err_q, axi_err_q;

  logic    grant_valid;
  req_id_e grant_id;
  logic    aw_hs, w_hs, b_hs, ar_hs, r_hs;

  riscv_axi_arb_select u_select (
`ifdef RISCV_AXI_ARB_RR_EN
    .clk_i         (ACLK),
    .rst_i         (ARESET),
    .grant_en_i    (state_q == IDLE),
`endif
    .if_req_i      (bus.if_req),
    .dm_req_i      (bus.dm_req),
    .grant_valid_o (grant_valid),
    .grant_id_o    (grant_id)
  );

  assign aw_hs = bus.M00_AXI_AWVALID & bus.M00_AXI_AWREADY;
  assign w_hs  = bus.M00_AXI_WVALID  & bus.M00_AXI_WREADY;
  assign b_hs  = bus.M00_AXI_BVALID  & bus.M00_AXI_BREADY;
  assign ar_hs = bus.M00_AXI_ARVALID & bus.M00_AXI_ARREADY;
  assign r_hs  = bus.M00_AXI_RVALID  & bus.M00_AXI_RREADY;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          state_d = (grant_id == REQ_DM && bus.dm_we) ? WR_REQ : RD_REQ;
        end
      end
      WR_REQ: begin
        if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
          state_d = WR_RESP;
        end
      end
      WR_RESP: if (b_hs) state_d = DONE;
      RD_REQ:  if (ar_hs) state_d = RD_DATA;
      RD_DATA: if (r_hs) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch, per-channel write completion, and response capture.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      id_q       <= REQ_IF;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      if_err_q   <= 1'b0;
      dm_err_q   <= 1'b0;
      axi_err_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          aw_done_q <= 1'b0;
          w_done_q  <= 1'b0;
          if (grant_valid) begin
            id_q    <= grant_id;
            we_q    <= (grant_id == REQ_DM) && bus.dm_we;
            addr_q  <= (grant_id == REQ_DM) ? bus.dm_addr : bus.if_addr;
            wdata_q <= bus.dm_wdata;
            wstrb_q <= bus.dm_wstrb;
          end
        end
        WR_REQ: begin
          if (aw_hs) aw_done_q <= 1'b1;
          if (w_hs)  w_done_q  <= 1'b1;
        end
        WR_RESP: begin
          if (b_hs) begin
            dm_rdata_q <= '0;
            dm_err_q   <= resp_is_err(bus.M00_AXI_BRESP);
            axi_err_q  <= axi_err_q | resp_is_err(bus.M00_AXI_BRESP);
          end
        end
        RD_DATA: begin
          if (r_hs) begin
            if (id_q == REQ_IF) begin
              if_rdata_q <= bus.M00_AXI_RDATA;
              if_err_q   <= resp_is_err(bus.M00_AXI_RRESP);
            end else begin
              dm_rdata_q <= bus.M00_AXI_RDATA;
              dm_err_q   <= resp_is_err(bus.M00_AXI_RRESP);
            end
            axi_err_q <= axi_err_q | resp_is_err(bus.M00_AXI_RRESP);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.M00_AXI_AWVALID = 1'b0;
    bus.M00_AXI_WVALID  = 1'b0;
    bus.M00_AXI_BREADY  = 1'b0;
    bus.M00_AXI_ARVALID = 1'b0;
    bus.M00_AXI_RREADY  = 1'b0;
    bus.if_ack          = 1'b0;
    bus.dm_ack          = 1'b0;
    case (state_q)
      WR_REQ: begin
        bus.M00_AXI_AWVALID = ~aw_done_q;
        bus.M00_AXI_WVALID  = ~w_done_q;
      end
      WR_RESP: bus.M00_AXI_BREADY  = 1'b1;
      RD_REQ:  bus.M00_AXI_ARVALID = 1'b1;
      RD_DATA: bus.M00_AXI_RREADY  = 1'b1;
      DONE: begin
        bus.if_ack = (id_q == REQ_IF);
        bus.dm_ack = (id_q == REQ_DM);
      end
      default: ;
    endcase
  end

  assign bus.M00_AXI_AWADDR = addr_q;
  assign bus.M00_AXI_AWPROT = PROT_DATA;
  assign bus.M00_AXI_WDATA  = wdata_q;
  assign bus.M00_AXI_WSTRB  = wstrb_q;
  assign bus.M00_AXI_ARADDR = addr_q;
  assign bus.M00_AXI_ARPROT = (id_q == REQ_IF) ? PROT_INSTR : PROT_DATA;
  assign bus.if_rdata       = if_rdata_q;
  assign bus.if_err         = if_err_q;
  assign bus.dm_rdata       = dm_rdata_q;
  assign bus.dm_err         = dm_err_q;
  assign bus.busy           = (state_q != IDLE);
  assign bus.M00_AXI_ERROR  = axi_err_q;

  logic unused_we;
  assign unused_we = we_q;

endmodule
